// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target-side responder.
// Holds the frame width, the chip-select idle level and the FSM state encoding.
// Ports: none (package).
package spi_pkg;

    localparam int FRAME_BITS = 32;

    // Chip select is active-low, so the bus is idle while CS is high.
    localparam logic CS_IDLE_LEVEL = 1'b1;

    // Bit counter is 6 bits and saturates one past a full frame, so that
    // any overlong frame stays distinguishable from a good one.
    localparam int         BIT_CNT_W   = 6;
    localparam logic [5:0] BIT_CNT_SAT = 6'd33;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_responder_if.sv
// Bundle of SPI pins plus the local-logic side of the responder.
// Ports: slave modport (responder view), master modport (bench / board master view).
// Optional FRAME_CNT signal exists only when SPI_SLAVE_FRAME_CNT_EN is defined.
interface spi_slave_responder_if
`ifdef SPI_SLAVE_FRAME_CNT_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    import spi_pkg::*;

    logic                  SPI_SCLK;
    logic                  SPI_CS;
    logic                  SPI_MOSI;
    logic                  SPI_MISO;
    logic [FRAME_BITS-1:0] TX_DATA;
    logic                  TX_TAKEN;
    logic [FRAME_BITS-1:0] RX_DATA;
    logic                  RX_VALID;
    logic                  RX_ERR;
`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [CNT_W-1:0]      FRAME_CNT;
`endif

    modport slave (
        input  SPI_SCLK, SPI_CS, SPI_MOSI, TX_DATA,
        output SPI_MISO, TX_TAKEN, RX_DATA, RX_VALID, RX_ERR
`ifdef SPI_SLAVE_FRAME_CNT_EN
        , output FRAME_CNT
`endif
    );

    modport master (
        output SPI_SCLK, SPI_CS, SPI_MOSI, TX_DATA,
        input  SPI_MISO, TX_TAKEN, RX_DATA, RX_VALID, RX_ERR
`ifdef SPI_SLAVE_FRAME_CNT_EN
        , input FRAME_CNT
`endif
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus one history flop for edge detection.
// Ports: clk_i/rst_i, async input d_i; synced level_o, one-cycle rise_o/fall_o pulses.
// RST_VAL sets the reset value of every flop in the chain.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~hist_q;
    assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversamples SCLK/CS/MOSI, captures 32-bit frames, shifts a response on MISO.
// Ports: CLOCK, RESET (async active-high), bus (slave modport: SPI pins, TX_DATA/TX_TAKEN,
// RX_DATA/RX_VALID/RX_ERR). Define SPI_SLAVE_FRAME_CNT_EN to add the FRAME_CNT good-frame counter.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = 32,
    parameter int CNT_W      = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    spi_slave_responder_if.slave bus
);

    if (FRAME_BITS != 32) begin : g_bad_frame_bits
        $error("spi_slave_responder: FRAME_BITS must be 32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("spi_slave_responder: CNT_W must be at least 1");
    end

    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(CLOCK), .rst_i(RESET), .d_i(bus.SPI_SCLK),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(CS_IDLE_LEVEL)) u_sync_cs (
        .clk_i(CLOCK), .rst_i(RESET), .d_i(bus.SPI_CS),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(CLOCK), .rst_i(RESET), .d_i(bus.SPI_MOSI),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_sync_bits;
    assign unused_sync_bits = ^{sclk_lvl, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [1:0]              prime_q, prime_d;
    logic [FRAME_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [BIT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic                    tx_taken_q, tx_taken_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_err_q, rx_err_d;
    logic                    miso;

    // The CS synchroniser resets to the idle level, so right after reset it
    // reads "idle" even if the pin is low. Hold WAIT_IDLE until the whole
    // chain has been refilled from the pin; otherwise a frame already in
    // progress would look like a fresh CS fall.
    logic primed;
    assign primed = (prime_q == 2'd3);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (primed && (cs_lvl == CS_IDLE_LEVEL)) state_d = IDLE;
            IDLE:      if (cs_fall) state_d = ACTIVE;
            ACTIVE:    if (cs_rise) state_d = IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        prime_d    = primed ? prime_q : prime_q + 2'd1;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        tx_taken_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        miso       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_sh_d    = bus.TX_DATA;
                    tx_taken_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            ACTIVE: begin
                miso = tx_sh_q[FRAME_BITS-1];
                // CS rise takes priority over a coincident SCLK edge.
                if (cs_rise) begin
                    if (cnt_q == FULL_CNT) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], mosi_lvl};
                    if (cnt_q != BIT_CNT_SAT) begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // Zero-fill so bits past the frame end go out as 0.
                    tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            prime_q    <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            tx_taken_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            prime_q    <= prime_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            tx_taken_q <= tx_taken_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign bus.SPI_MISO = miso;
    assign bus.TX_TAKEN = tx_taken_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.RX_ERR   = rx_err_q;

`ifdef SPI_SLAVE_FRAME_CNT_EN
    // Steps together with RX_VALID so the new count is visible in the pulse cycle.
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            frame_cnt_q <= '0;
        end else if (rx_valid_d) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign bus.FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bit-banged SPI mode-0 master at SCLK = CLOCK/16.
// Checks reset state, good/short/long frames, reset mid-frame, back-to-back frames
// and (with SPI_SLAVE_FRAME_CNT_EN) the frame counter wrap.
module tb_spi_slave_responder;

    logic CLOCK;
    logic RESET;

`ifdef SPI_SLAVE_FRAME_CNT_EN
    spi_slave_responder_if #(.CNT_W(4)) bus ();
`else
    spi_slave_responder_if bus ();
`endif

    spi_slave_responder #(.FRAME_BITS(32), .CNT_W(4)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;

    int n_taken = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [31:0] rx_log[$];

    // Pulse monitor: counts high cycles of each strobe and logs RX_DATA at RX_VALID.
    always @(negedge CLOCK) begin
        if (bus.TX_TAKEN === 1'b1) n_taken++;
        if (bus.RX_ERR === 1'b1)   n_err++;
        if (bus.RX_VALID === 1'b1) begin
            n_valid++;
            rx_log.push_back(bus.RX_DATA);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // Master side of one frame, MSB first. MISO is sampled at each SCLK rise.
    // rst_at > 0 pulses RESET right after that many bits have been clocked.
    task automatic send_frame(input logic [63:0] data, input int nbits,
                              input int rst_at, output logic [63:0] got);
        got = '0;
        bus.SPI_CS = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            bus.SPI_MOSI = data[nbits-1-i];
            wait_clk(8);
            bus.SPI_SCLK = 1'b1;
            got = {got[62:0], bus.SPI_MISO};
            wait_clk(8);
            bus.SPI_SCLK = 1'b0;
            if (i + 1 == rst_at) begin
                RESET = 1'b1;
                wait_clk(3);
                RESET = 1'b0;
            end
        end
        bus.SPI_MOSI = 1'b0;
        wait_clk(8);
        bus.SPI_CS = 1'b1;
    endtask

    logic [63:0] got;
    logic [63:0] got_b2b[3];
    int v0, e0, t0;

    initial begin
        RESET        = 1'b1;
        bus.SPI_CS   = 1'b1;
        bus.SPI_SCLK = 1'b0;
        bus.SPI_MOSI = 1'b0;
        bus.TX_DATA  = 32'h0;
        wait_clk(5);
        RESET = 1'b0;
        wait_clk(10);

        // Reset state
        chk("reset_miso",     {63'h0, bus.SPI_MISO}, 64'h0);
        chk("reset_tx_taken", {63'h0, bus.TX_TAKEN}, 64'h0);
        chk("reset_rx_data",  {32'h0, bus.RX_DATA},  64'h0);
        chk("reset_rx_valid", {63'h0, bus.RX_VALID}, 64'h0);
        chk("reset_rx_err",   {63'h0, bus.RX_ERR},   64'h0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
        chk("reset_frame_cnt", {60'h0, bus.FRAME_CNT}, 64'h0);
`endif

        // Good frame
        bus.TX_DATA = 32'hDEADBEEF;
        v0 = n_valid; e0 = n_err; t0 = n_taken;
        send_frame(64'hA5A51234, 32, 0, got);
        wait_clk(10);
        chk("good_rx_data",   {32'h0, bus.RX_DATA}, 64'hA5A51234);
        chk("good_valid_cnt", 64'(n_valid - v0), 64'd1);
        chk("good_err_cnt",   64'(n_err - e0),   64'd0);
        chk("good_taken_cnt", 64'(n_taken - t0), 64'd1);
        chk("good_miso_word", got,               64'hDEADBEEF);
        chk("good_log_data",  {32'h0, rx_log[$]}, 64'hA5A51234);
        chk("idle_miso_zero", {63'h0, bus.SPI_MISO}, 64'h0);

        // Short frame: 16 bits
        v0 = n_valid; e0 = n_err;
        send_frame(64'h1234, 16, 0, got);
        wait_clk(10);
        chk("short_err_cnt",   64'(n_err - e0),   64'd1);
        chk("short_valid_cnt", 64'(n_valid - v0), 64'd0);
        chk("short_rx_data",   {32'h0, bus.RX_DATA}, 64'hA5A51234);

        // Long frame: 33 bits, bit past the word must read 0
        bus.TX_DATA = 32'hFFFFFFFF;
        v0 = n_valid; e0 = n_err;
        send_frame(64'h1_5555_AAAA, 33, 0, got);
        wait_clk(10);
        chk("long_err_cnt",   64'(n_err - e0),   64'd1);
        chk("long_valid_cnt", 64'(n_valid - v0), 64'd0);
        chk("long_miso_word", {32'h0, got[32:1]}, 64'hFFFFFFFF);
        chk("long_miso_bit33", {63'h0, got[0]},   64'h0);
        chk("long_rx_data",   {32'h0, bus.RX_DATA}, 64'hA5A51234);

        // Reset after 10 bits, released with CS still low, frame completed
        bus.TX_DATA = 32'h12345678;
        v0 = n_valid; e0 = n_err;
        send_frame(64'hCAFEF00D, 32, 10, got);
        wait_clk(10);
        chk("rstmid_valid_cnt", 64'(n_valid - v0), 64'd0);
        chk("rstmid_err_cnt",   64'(n_err - e0),   64'd0);
        chk("rstmid_rx_data",   {32'h0, bus.RX_DATA}, 64'h0);
        v0 = n_valid;
        send_frame(64'h00000001, 32, 0, got);
        wait_clk(10);
        chk("after_rst_valid_cnt", 64'(n_valid - v0), 64'd1);
        chk("after_rst_rx_data",   {32'h0, bus.RX_DATA}, 64'h1);

        // Three back-to-back frames with 4-cycle CS-high gaps, TX_DATA changed each time
        rx_log.delete();
        v0 = n_valid; e0 = n_err;
        bus.TX_DATA = 32'h80000001;
        send_frame(64'h1, 32, 0, got_b2b[0]);
        bus.TX_DATA = 32'h40000002;
        wait_clk(4);
        send_frame(64'h2, 32, 0, got_b2b[1]);
        bus.TX_DATA = 32'h3C3C0003;
        wait_clk(4);
        send_frame(64'h3, 32, 0, got_b2b[2]);
        wait_clk(10);
        chk("b2b_valid_cnt", 64'(n_valid - v0), 64'd3);
        chk("b2b_err_cnt",   64'(n_err - e0),   64'd0);
        chk("b2b_log_len",   64'(rx_log.size()), 64'd3);
        if (rx_log.size() == 3) begin
            chk("b2b_rx0", {32'h0, rx_log[0]}, 64'h1);
            chk("b2b_rx1", {32'h0, rx_log[1]}, 64'h2);
            chk("b2b_rx2", {32'h0, rx_log[2]}, 64'h3);
        end
        chk("b2b_miso0", got_b2b[0], 64'h80000001);
        chk("b2b_miso1", got_b2b[1], 64'h40000002);
        chk("b2b_miso2", got_b2b[2], 64'h3C3C0003);

`ifdef SPI_SLAVE_FRAME_CNT_EN
        // Frame counter: 17 good frames from zero wrap a 4-bit counter to 1
        RESET = 1'b1;
        wait_clk(3);
        RESET = 1'b0;
        wait_clk(10);
        chk("cnt_after_reset", {60'h0, bus.FRAME_CNT}, 64'h0);
        v0 = n_valid; e0 = n_err;
        for (int f = 0; f < 17; f++) begin
            bus.TX_DATA = 32'(f);
            send_frame(64'(f + 100), 32, 0, got);
            wait_clk(6);
        end
        wait_clk(6);
        chk("cnt_valid_17",  64'(n_valid - v0), 64'd17);
        chk("cnt_wrap",      {60'h0, bus.FRAME_CNT}, 64'h1);
        send_frame(64'h55, 8, 0, got);
        wait_clk(10);
        chk("cnt_short_err", 64'(n_err - e0), 64'd1);
        chk("cnt_after_short", {60'h0, bus.FRAME_CNT}, 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

Target-side end of the 32-bit SPI link used by the board's SPI master (GO/DONE handshake, CS active-low, mode 0, MSB-first). Oversamples SCLK/CS/MOSI in the fabric clock domain and captures each 32-bit frame. Simultaneously shifts out a 32-bit response word on MISO. Presents captured words to local logic with a one-cycle valid strobe. Used for loopback verification of the SPI master and as the slave front end on daughter boards.

## Interface
- FRAME_BITS, 32, bits per frame; fixed at 32 in this release. Any other value is a synthesis error.
- CNT_W, 16, width of the good-frame counter; only used with the macro below.
- CLOCK  in  1  fabric clock (CLK_80MHZ); must be ≥ 8× SCLK frequency.
- RESET  in  1  reset; asynchronous, active-high.
- SPI_SCLK  in  1  serial clock from master, idle low.
- SPI_CS  in  1  chip select, active-low.
- SPI_MOSI  in  1  master-out data.
- SPI_MISO  out  1  slave-out data; 0 while CS high; reset 0.
- TX_DATA  in  32  response word; sampled on detected CS fall.
- TX_TAKEN  out  1  one-cycle pulse when TX_DATA is latched; reset 0.
- RX_DATA  out  32  last good frame; held until the next good frame; reset 0.
- RX_VALID  out  1  one-cycle pulse, RX_DATA updated; reset 0.
- RX_ERR  out  1  one-cycle pulse, frame had bit count ≠ 32; reset 0.
- FRAME_CNT  out  CNT_W  good-frame count; present only with SPI_SLAVE_FRAME_CNT_EN; reset 0.

## Operation
- Synchronisation:
  - Each of SCLK, CS and MOSI passes through 2 flops, followed by one history flop for edge detection.
  - CS sync flops reset to 1. SCLK and MOSI sync flops reset to 0.
- States:
  - WAIT_IDLE: reset state. Go to IDLE when the synced CS is 1. This prevents capturing a frame already in progress at reset release.
  - IDLE: on CS fall, latch TX_DATA into the tx shifter, pulse TX_TAKEN, clear the bit counter, go to ACTIVE.
  - ACTIVE: on each SCLK rise, shift the synced MOSI into the rx shifter LSB and increment the 6-bit counter (saturates at 33). On each SCLK fall, shift the tx shifter left. On CS rise, go to IDLE and evaluate the frame.
- Frame evaluation on CS rise:
  - Count == 32: RX_DATA ← rx shifter, pulse RX_VALID.
  - Any other count, including 0 and ≥ 33: pulse RX_ERR; RX_DATA unchanged.
- MISO:
  - Equals tx shifter bit 31 in ACTIVE, 0 otherwise.
  - First bit is valid before the first SCLK rise.
  - Bits beyond 32 shift out as 0.
- Simultaneous SCLK edge and CS rise in one cycle: the CS rise wins and the SCLK edge is ignored.
- SCLK edges while CS is high are ignored.
- Reset mid-frame: the frame is discarded, all outputs return to reset values, and the FSM waits in WAIT_IDLE.

## Timing
- Pin-to-detect latency is 3 CLOCK cycles for all inputs.
- TX_TAKEN pulses 1 cycle after CS fall is detected.
  - MISO shows TX_DATA[31] in that same cycle, 4 cycles after the CS pin falls.
- MISO updates 1 cycle after a detected SCLK fall. That is ≤ 4 cycles after the pin, well within the half period at ≥ 8× oversampling.
- RX_VALID / RX_ERR pulse 1 cycle after CS rise is detected, 4 cycles after the CS pin rises.
  - RX_DATA changes in the same cycle as RX_VALID.
- Minimum CS-high time between frames is 4 CLOCK cycles. Back-to-back frames are then all accepted.
- TX_DATA must be stable from 1 cycle before the CS fall is detected until TX_TAKEN.

## Configuration
- SPI_SLAVE_FRAME_CNT_EN:
  - Defined: FRAME_CNT port and counter exist. The counter increments by 1 in the RX_VALID cycle, wraps from 2^CNT_W−1 to 0, and is not affected by RX_ERR.
  - Undefined: port, counter and CNT_W logic are absent; all other behaviour is identical.

## Structure
- Shared package spi_pkg holds:
  - the FRAME_BITS constant;
  - the state enumeration WAIT_IDLE/IDLE/ACTIVE (2-bit encoding);
  - the CS_IDLE_LEVEL constant.
- One sub-module, spi_sync_edge: a 2-flop synchroniser plus history flop, with parameterised reset value. It outputs the synced level plus rise and fall pulses and is instantiated three times.

## Test plan
- TX_DATA=0xDEADBEEF, master sends 0xA5A51234 at SCLK=CLOCK/16:
  - RX_DATA=0xA5A51234 with one RX_VALID pulse.
  - Master receives 0xDEADBEEF.
  - One TX_TAKEN pulse.
- Short frame of 16 bits (0x1234), CS released:
  - RX_ERR pulses once, no RX_VALID, RX_DATA keeps its previous 0xA5A51234.
- 33-bit frame:
  - RX_ERR pulses.
  - MISO bit 33 = 0.
  - RX_DATA unchanged.
- RESET asserted after 10 bits, released while CS is still low, master completes the frame:
  - No RX_VALID and no RX_ERR.
  - The next full frame 0x00000001 gives RX_VALID with RX_DATA=0x00000001.
- Three back-to-back frames with 4-cycle CS-high gaps (0x1, 0x2, 0x3):
  - Three RX_VALID pulses in order.
  - TX_DATA changed between frames is reflected on MISO.
- With SPI_SLAVE_FRAME_CNT_EN and CNT_W=4, send 17 good frames and 1 short frame:
  - FRAME_CNT=1 after wrap.
  - The short frame does not increment the counter.
